mul_share_ctrl: RTL and testbench

Controller that time-shares one 3-bit sign-magnitude multiplier (`mul`: a[2:0], b[2:0] -> product[4:0], zeroFlag) between two requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Drives the multiplier, waits a programmable latency, then captures and normalises the result.
- Returns the result to the winner with a one-cycle done pulse.
- Sits between the two ALU front-ends and the single shared `mul` instance.

---
 rtl/mul_share_ctrl.sv | 144 ++++++++++++++
 tb/tb_mul_share_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Time-shares one 3-bit sign-magnitude multiplier between two requesters:
// arbitrates, drives the operands, waits MUL_LATENCY cycles, returns the result.
module mul_share_ctrl #(
  parameter int unsigned MUL_LATENCY = 1,
  parameter bit          FAIR        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic       req1,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [4:0] res_product,
  output logic       res_zero,
  output logic       busy,
  output logic [2:0] mul_a,
  output logic [2:0] mul_b,
  input  logic [4:0] mul_product,
  input  logic       mul_zero
);

  // state | meaning
  // IDLE  | multiplier free, arbitrating requests
  // BUSY  | operands on mul_a/mul_b, latency counter running
  // DONE  | result captured, done pulse to the owner
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT = 4'(MUL_LATENCY);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;
  logic [4:0] res_product_q, res_product_d;
  logic       res_zero_q, res_zero_d;
  logic [2:0] mul_a_q, mul_a_d;
  logic [2:0] mul_b_q, mul_b_d;
  logic       pick1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    gnt0_d        = gnt0_q;
    gnt1_d        = gnt1_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    res_product_d = res_product_q;
    res_zero_d    = res_zero_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    // On a tie, FAIR picks whoever was not served last; otherwise requester 0.
    pick1 = req1 & (~req0 | (FAIR & ~last_q));

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          last_d  = pick1;
          mul_a_d = pick1 ? a1 : a0;
          mul_b_d = pick1 ? b1 : b0;
          cnt_d   = LAT;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d       = DONE;
          cnt_d         = 4'd0;
          res_product_d = {mul_product[4] & ~mul_zero, mul_product[3:0]};
          res_zero_d    = mul_zero;
          done0_d       = gnt0_q;
          done1_d       = gnt1_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      last_q        <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      busy_q        <= 1'b0;
      res_product_q <= 5'd0;
      res_zero_q    <= 1'b0;
      mul_a_q       <= 3'd0;
      mul_b_q       <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      busy_q        <= busy_d;
      res_product_q <= res_product_d;
      res_zero_q    <= res_zero_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign busy        = busy_q;
  assign res_product = res_product_q;
  assign res_zero    = res_zero_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: two instances (latency 1 fair, latency 3 fixed-priority)
// checked every cycle against a transaction-timestamp reference model.
module tb_mul_share_ctrl;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0[2], req1[2];
  logic [2:0] a0[2], b0[2], a1[2], b1[2];
  logic       gnt0[2], gnt1[2], done0[2], done1[2], busy[2], res_zero[2], mul_zero[2];
  logic [4:0] res_product[2], mul_product[2];
  logic [2:0] mul_a[2], mul_b[2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state: owner (-1 idle), grant timestamp, last grant, latched ops, result
  int         owner[2] = '{-1, -1};
  int         t_gnt[2] = '{0, 0};
  int         last[2]  = '{1, 1};
  logic [2:0] m_a[2], m_b[2];
  logic [4:0] m_res[2];
  logic       m_zero[2];

  always #5 clk = ~clk;

  mul_share_ctrl #(.MUL_LATENCY(LAT_A), .FAIR(1'b1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .a0(a0[0]), .b0(b0[0]),
    .req1(req1[0]), .a1(a1[0]), .b1(b1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .res_product(res_product[0]), .res_zero(res_zero[0]), .busy(busy[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_product(mul_product[0]), .mul_zero(mul_zero[0])
  );

  mul_share_ctrl #(.MUL_LATENCY(LAT_B), .FAIR(1'b0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .a0(a0[1]), .b0(b0[1]),
    .req1(req1[1]), .a1(a1[1]), .b1(b1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .res_product(res_product[1]), .res_zero(res_zero[1]), .busy(busy[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_product(mul_product[1]), .mul_zero(mul_zero[1])
  );

  // shared multiplier stand-in: raw sign, so -0 shows up as 5'b10000 with zero=1
  function automatic logic [5:0] mul_fn(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] mag;
    mag = {2'b00, a[1:0]} * {2'b00, b[1:0]};
    return {mag == 4'd0, a[2] ^ b[2], mag};
  endfunction

  assign {mul_zero[0], mul_product[0]} = mul_fn(mul_a[0], mul_b[0]);
  assign {mul_zero[1], mul_product[1]} = mul_fn(mul_a[1], mul_b[1]);

  // expected {zero, normalised product}
  function automatic logic [5:0] ref_result(input logic [2:0] a, input logic [2:0] b);
    int mag;
    bit neg;
    mag = int'(a[1:0]) * int'(b[1:0]);
    neg = (a[2] != b[2]) && (mag != 0);
    return {mag == 0, neg, mag[3:0]};
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        owner[i] = -1; last[i] = 1;
        m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_zero[i] = 1'b0;
      end else if (owner[i] < 0) begin
        int w;
        w = -1;
        if (req0[i] && req1[i]) w = (i == 0) ? 1 - last[i] : 0;
        else if (req0[i])       w = 0;
        else if (req1[i])       w = 1;
        if (w >= 0) begin
          owner[i] = w; t_gnt[i] = cyc; last[i] = w;
          m_a[i] = (w == 1) ? a1[i] : a0[i];
          m_b[i] = (w == 1) ? b1[i] : b0[i];
        end
      end else if (cyc - t_gnt[i] == lat(i)) begin
        {m_zero[i], m_res[i]} = ref_result(m_a[i], m_b[i]);
      end else if (cyc - t_gnt[i] == lat(i) + 1) begin
        owner[i] = -1;
      end
    end
  endtask

  task automatic check_outputs(input int i);
    bit dn;
    dn = (owner[i] >= 0) && (cyc - t_gnt[i] == lat(i));
    check_eq($sformatf("u%0d gnt0", i), gnt0[i], owner[i] == 0);
    check_eq($sformatf("u%0d gnt1", i), gnt1[i], owner[i] == 1);
    check_eq($sformatf("u%0d done0", i), done0[i], dn && owner[i] == 0);
    check_eq($sformatf("u%0d done1", i), done1[i], dn && owner[i] == 1);
    check_eq($sformatf("u%0d busy", i), busy[i], owner[i] >= 0);
    check_eq($sformatf("u%0d res_product", i), res_product[i], m_res[i]);
    check_eq($sformatf("u%0d res_zero", i), res_zero[i], m_zero[i]);
    check_eq($sformatf("u%0d mul_a", i), mul_a[i], m_a[i]);
    check_eq($sformatf("u%0d mul_b", i), mul_b[i], m_b[i]);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      check_outputs(0);
      check_outputs(1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int i, output int who);
    who = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done0[i]) begin who = 0; break; end
      if (done1[i]) begin who = 1; break; end
    end
    if (who < 0) check_eq($sformatf("u%0d done timeout", i), 0, 1);
  endtask

  task automatic wait_gnt0(input int i);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = gnt0[i];
    end
    if (!seen) check_eq($sformatf("u%0d gnt0 timeout", i), 0, 1);
  endtask

  function automatic logic [6:0] next_req(input logic dn, input logic [6:0] cur);
    logic [6:0] nx;
    nx = cur;
    if (cur[6]) begin
      if (dn) begin
        if ($urandom_range(0, 3) != 0) nx[6] = 1'b0;
        else nx[5:0] = 6'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        nx[5:0] = 6'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      nx = {1'b1, 6'($urandom)};
    end
    return nx;
  endfunction

  task automatic run_random(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        {req0[i], a0[i], b0[i]} = next_req(done0[i], {req0[i], a0[i], b0[i]});
        {req1[i], a1[i], b1[i]} = next_req(done1[i], {req1[i], a1[i], b1[i]});
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int who;
    int c0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0;
      a0[i] = '0; b0[i] = '0; a1[i] = '0; b1[i] = '0;
    end
    idle(3);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset busy", busy[i], 0);
      check_eq("reset gnt", {gnt0[i], gnt1[i], done0[i], done1[i]}, 0);
      check_eq("reset res", {res_zero[i], res_product[i], mul_a[i], mul_b[i]}, 0);
    end
    rst = 1'b0;
    idle(2);

    // single op, latency 1
    req0[0] = 1'b1; a0[0] = 3'b011; b0[0] = 3'b110; c0 = cyc;
    wait_done(0, who);
    check_eq("t1 who", who, 0);
    check_eq("t1 latency", cyc - c0, 1 + LAT_A);
    check_eq("t1 res", res_product[0], 5'b10110);
    check_eq("t1 zero", res_zero[0], 1'b0);
    req0[0] = 1'b0;
    idle(3);

    // negative zero is normalised
    req1[0] = 1'b1; a1[0] = 3'b100; b1[0] = 3'b011;
    wait_done(0, who);
    check_eq("t2 who", who, 1);
    check_eq("t2 res", res_product[0], 5'b00000);
    check_eq("t2 zero", res_zero[0], 1'b1);
    req1[0] = 1'b0;
    idle(3);

    // held ties: round-robin on u0, fixed priority on u1
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b1; a0[i] = 3'b001; b0[i] = 3'b001;
      req1[i] = 1'b1; a1[i] = 3'b010; b1[i] = 3'b111;
      for (int k = 0; k < 3; k++) begin
        wait_done(i, who);
        check_eq($sformatf("t3 u%0d tie %0d", i, k), who, (i == 0) ? (k % 2) : 0);
      end
      req0[i] = 1'b0; req1[i] = 1'b0;
      idle(3);
    end

    // latency 3
    req0[1] = 1'b1; a0[1] = 3'b010; b0[1] = 3'b010; c0 = cyc;
    wait_done(1, who);
    check_eq("t4 who", who, 0);
    check_eq("t4 latency", cyc - c0, 1 + LAT_B);
    check_eq("t4 res", res_product[1], 5'b00100);
    check_eq("t4 mul_ab", {mul_a[1], mul_b[1]}, 6'b010010);
    req0[1] = 1'b0;
    idle(3);

    // operands change after grant
    req0[1] = 1'b1; a0[1] = 3'b001; b0[1] = 3'b011;
    wait_gnt0(1);
    a0[1] = 3'b111;
    wait_done(1, who);
    check_eq("t5 res", res_product[1], 5'b00011);
    req0[1] = 1'b0;
    idle(3);

    // reset mid-operation aborts
    req0[1] = 1'b1; a0[1] = 3'b011; b0[1] = 3'b011;
    wait_gnt0(1);
    rst = 1'b1; req0[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6 busy", busy[1], 0);
    check_eq("t6 gnt/done", {gnt0[1], gnt1[1], done0[1], done1[1]}, 0);
    check_eq("t6 res", {res_zero[1], res_product[1]}, 0);
    check_eq("t6 mul_ab", {mul_a[1], mul_b[1]}, 0);
    idle(6);

    // post-reset tie goes to requester 0
    req0[0] = 1'b1; req1[0] = 1'b1;
    a0[0] = 3'b101; b0[0] = 3'b011; a1[0] = 3'b001; b1[0] = 3'b001;
    wait_done(0, who);
    check_eq("t6 tie", who, 0);
    req0[0] = 1'b0; req1[0] = 1'b0;
    idle(3);

    // exhaustive operand sweep via requester 1
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        req1[0] = 1'b1; a1[0] = 3'(a); b1[0] = 3'(b);
        wait_done(0, who);
        check_eq($sformatf("sweep %0d*%0d", a, b), {res_zero[0], res_product[0]},
                 ref_result(3'(a), 3'(b)));
        req1[0] = 1'b0;
        idle(1);
      end
    end

    run_random(2500);
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0;
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
